mips32_test_sequencer: RTL

MIPS32_TEST_SEQUENCER -- requirements
Module: mips32_test_sequencer

---
 rtl/mips32_test_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mips32_test_sequencer.sv
// -----------------------------------------------------------------------------
// mips32_test_sequencer
//
// Runs one test of a MIPS32 core per accepted start:
//   1. LOAD    streams prog_len instruction words into the core's instruction
//              memory (valid/ready in, combinational write port out).
//   2. INIT    pulses core_init for one cycle (clears halted flag/PC/branch).
//   3. RUN     holds core_run until the core halts or TIMEOUT_CYC cycles pass.
//   4. RD_REQ / RD_WAIT / DUMP  reads registers 0..NUM_DUMP-1 through the
//              core's register-file port (one-cycle read latency) and presents
//              each one on a valid/ready dump stream.
//   5. DONE    one cycle, raises done; done/timeout hold until the next start.
//
// Ports
//   clk1, reset                 clock (rising edge), async active-high reset
//   start, prog_len             sequence request, program length in words
//   in_valid/in_ready/in_data   instruction-word input stream
//   mem_we/mem_addr/mem_wdata   core instruction-memory write port
//   core_init, core_run         core control; core_halted from the core
//   reg_rd_en/idx/data          core register-file read port
//   dump_valid/ready/idx/data   register dump output stream
//   busy, done, timeout         status
// -----------------------------------------------------------------------------
module mips32_test_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int NUM_DUMP    = 6,
  parameter int TIMEOUT_CYC = 300
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_init,
  output logic              core_run,
  input  logic              core_halted,
  output logic              reg_rd_en,
  output logic [4:0]        reg_rd_idx,
  input  logic [31:0]       reg_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_idx,
  output logic [31:0]       dump_data,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LEN_W-1:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]       DUMP_LAST = 5'(NUM_DUMP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_RUN, S_RD_REQ, S_RD_WAIT, S_DUMP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] ld_cnt_q;
  logic [CNT_W-1:0] cyc_q;
  logic [4:0]       dcnt_q;
  logic [4:0]       dump_idx_q;
  logic [31:0]      dump_data_q;
  logic             done_q;
  logic             timeout_q;

  // Program lengths beyond the memory size are clamped to a full memory.
  logic [LEN_W-1:0] len_clamped;
  assign len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (prog_len == '0) ? S_INIT : S_LOAD;
      S_LOAD:    if (in_valid && (ld_cnt_q == len_q - LEN_W'(1))) state_d = S_INIT;
      S_INIT:    state_d = S_RUN;
      // A halt seen on the final allowed cycle wins over the timeout.
      S_RUN:     if (core_halted || (cyc_q == CYC_LAST)) state_d = S_RD_REQ;
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_DUMP;
      S_DUMP:    if (dump_ready) state_d = (dcnt_q == DUMP_LAST) ? S_DONE : S_RD_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_init  = 1'b0;
    core_run   = 1'b0;
    reg_rd_en  = 1'b0;
    reg_rd_idx = '0;
    dump_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ld_cnt_q[ADDR_W-1:0];
          mem_wdata = in_data;
        end
      end
      S_INIT:   core_init = 1'b1;
      S_RUN:    core_run  = 1'b1;
      S_RD_REQ: begin
        reg_rd_en  = 1'b1;
        reg_rd_idx = dcnt_q;
      end
      S_DUMP:   dump_valid = 1'b1;
      S_DONE:   busy = 1'b0;
      default:  busy = 1'b1;
    endcase
  end

  assign dump_idx  = dump_idx_q;
  assign dump_data = dump_data_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

  // ---------------------------------------------------------------------------
  // Counters and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      len_q       <= '0;
      ld_cnt_q    <= '0;
      cyc_q       <= '0;
      dcnt_q      <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q     <= len_clamped;
            ld_cnt_q  <= '0;
            dcnt_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_LOAD: if (in_valid) ld_cnt_q <= ld_cnt_q + LEN_W'(1);
        S_INIT: cyc_q <= '0;
        S_RUN: begin
          cyc_q <= cyc_q + CNT_W'(1);
          if (!core_halted && (cyc_q == CYC_LAST)) timeout_q <= 1'b1;
        end
        // Register-file data is valid the cycle after the read request.
        S_RD_WAIT: begin
          dump_data_q <= reg_rd_data;
          dump_idx_q  <= dcnt_q;
        end
        S_DUMP: begin
          if (dump_ready) begin
            if (dcnt_q == DUMP_LAST) done_q <= 1'b1;
            else                     dcnt_q <= dcnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
